pipeline_issue: RTL and testbench
=================================

Name: pipeline_issue

Overview:
- Head-of-pipeline issuer; sits directly upstream of the first pipeline_stage.
- Accepts address requests over a valid/ready handshake, tags each with a unique in-order ID, and presents address/id/valid to stage 0, honouring that stage's stall.
- Tracks outstanding IDs until they are retired by the pipeline tail or cancelled.
- Converts cancels into the flush/flush_id broadcast consumed by the stages.

Parameters:
- ADDRESS_WIDTH, `ADDRESS_WIDTH, width of request address.
- ID_WIDTH, `ID_WIDTH, width of transaction ID; ID space is 2^ID_WIDTH.
- MAX_OUTSTANDING, 2^ID_WIDTH, cap on IDs in flight; legal range 1..2^ID_WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_address  in  ADDRESS_WIDTH  request address.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- out_address  out  ADDRESS_WIDTH  address to stage 0.
- out_id  out  ID_WIDTH  ID to stage 0.
- out_valid  out  1  beat valid to stage 0.
- in_stall  in  1  stall from stage 0.
- cancel_valid  in  1  cancel request.
- cancel_id  in  ID_WIDTH  ID to cancel.
- out_flush  out  1  flush pulse to stages.
- out_flush_id  out  ID_WIDTH  ID being flushed.
- retire_valid  in  1  pipeline tail completed an ID.
- retire_id  in  ID_WIDTH  completed ID.
- drain  in  1  level; stop accepting new requests.
- drained  out  1  drain active and nothing outstanding.
- outstanding  out  ID_WIDTH+1  count of IDs in flight.

Behaviour:
- Reset (async, reset_n low): out_valid=0, out_address=0, out_id=0, out_flush=0, out_flush_id=0, next_id=0, bitmap=0, outstanding=0, FSM=RUN. req_ready=0 while in reset.
- Handshake to stage 0: a beat is consumed on any edge with out_valid=1 and in_stall=0. While in_stall=1, out_address, out_id and out_valid hold stable.
- can_alloc = FSM==RUN and bitmap[next_id]==0 and outstanding<MAX_OUTSTANDING.
- req_ready = can_alloc and (out_valid==0 or in_stall==0). It is combinational from in_stall.
- On accept:
  - Next cycle: out_address=req_address (unmodified; stages add their own offsets), out_id=next_id, out_valid=1.
  - bitmap[next_id] set; outstanding increments; next_id increments mod 2^ID_WIDTH.
  - Latency is 1 cycle. Back-to-back accepts give 1 beat/cycle when there is no stall.
- If the output is consumed with no new accept, out_valid becomes 0.
- An ID is counted outstanding from accept until retire or cancel. A beat still held in the output register is also outstanding.
- Retire: if retire_valid and bitmap[retire_id], clear the bit and decrement outstanding. Retire of a non-outstanding ID is ignored.
- Cancel: if cancel_valid and bitmap[cancel_id]:
  - Clear the bit and decrement outstanding.
  - Next cycle: out_flush=1 for exactly one cycle, out_flush_id=cancel_id.
  - If cancel_id equals out_id with out_valid=1, out_valid is cleared next cycle. This takes priority over stall hold.
  - Cancel of a non-outstanding ID: no flush pulse, no state change.
- Same-cycle retire and cancel of the same ID: clear once, decrement by 1, and still emit the flush.
- Same-cycle retire/cancel of different IDs: both apply; outstanding changes by -2.
- Same-cycle accept and free: the net count is updated by a single adder. The count never exceeds MAX_OUTSTANDING or underflows.
- Wrap: if next_id is still outstanding, allocation blocks (req_ready=0) until that ID frees. IDs are never skipped.
- FSM:
  - RUN -> DRAIN when drain=1. In DRAIN, req_ready=0; the held beat, retires and cancels continue.
  - DRAIN -> RUN when drain=0.
  - drained = (FSM==DRAIN and outstanding==0), registered.
- in_stall is ignored when out_valid=0.

Decomposition:
- ADDRESS_WIDTH and ID_WIDTH come from the shared defines.vh.
- Add ISSUE_STATE_RUN/ISSUE_STATE_DRAIN encodings and the MAX_OUTSTANDING default to the same shared header.
- Sub-module id_tracker: owns the bitmap, the outstanding counter, and the alloc/retire/cancel ports. It reports busy[next_id] and count.

Test Plan:
- Reset, then 3 requests 0x10, 0x20, 0x30 back-to-back with in_stall=0 -> out beats (0x10,id0), (0x20,id1), (0x30,id2) on consecutive cycles, 1-cycle latency; outstanding=3.
- Hold in_stall=1 for 4 cycles with req_valid=1 and the output holding (0x20,id1) -> outputs stable, req_ready=0; after release id2 follows in the next cycle.
- ID_WIDTH=2: issue 4 requests, no retires -> req_ready=0 with next_id=0 busy; retire id0 -> exactly one accept, tagged id0.
- Cancel id1 while it is outstanding -> one-cycle out_flush=1, out_flush_id=1, outstanding decrements; cancel id1 again -> no pulse.
- Cancel the ID currently held under in_stall=1 -> out_valid=0 next cycle and a flush pulse; retire and cancel of the same ID in one cycle -> outstanding drops by 1.
- Assert drain with 2 outstanding -> req_ready=0; retire both -> drained=1 a cycle later. Assert reset_n low mid-traffic -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/pipeline_issue_pkg.sv
// Shared types and default widths for the pipeline issue block.
package pipeline_issue_pkg;

  localparam int DEFAULT_ADDRESS_WIDTH   = 16;
  localparam int DEFAULT_ID_WIDTH        = 3;
  localparam int DEFAULT_MAX_OUTSTANDING = 1 << DEFAULT_ID_WIDTH;

  // Issue control state: RUN accepts requests, DRAIN lets in-flight work finish.
  typedef enum logic {
    ISSUE_STATE_RUN   = 1'b0,
    ISSUE_STATE_DRAIN = 1'b1
  } issue_state_e;

endpackage

// File: rtl/pipeline_issue_id_tracker.sv
// Outstanding-ID bookkeeping: one busy bit per ID plus a running count.
// Retire and cancel only act on IDs whose bit is set, so stale frees are harmless.
module pipeline_issue_id_tracker
  import pipeline_issue_pkg::*;
#(
  parameter int ID_WIDTH = DEFAULT_ID_WIDTH
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_alloc_valid,
  input  logic [ID_WIDTH-1:0] i_alloc_id,
  input  logic                i_retire_valid,
  input  logic [ID_WIDTH-1:0] i_retire_id,
  input  logic                i_cancel_valid,
  input  logic [ID_WIDTH-1:0] i_cancel_id,
  input  logic [ID_WIDTH-1:0] i_query_id,
  output logic                o_query_busy,
  output logic                o_cancel_hit,
  output logic [ID_WIDTH:0]   o_count
);

  localparam int NUM_IDS = 1 << ID_WIDTH;

  logic [NUM_IDS-1:0] r_bitmap;
  logic [NUM_IDS-1:0] w_bitmap_next;
  logic [ID_WIDTH:0]  r_count;
  logic               w_retire_hit;
  logic               w_cancel_hit;
  logic               w_same_id;
  logic [1:0]         w_free_cnt;

  assign w_retire_hit = i_retire_valid && r_bitmap[i_retire_id];
  assign w_cancel_hit = i_cancel_valid && r_bitmap[i_cancel_id];
  assign w_same_id    = w_retire_hit && w_cancel_hit && (i_retire_id == i_cancel_id);

  // A retire and cancel of the same ID frees it only once.
  assign w_free_cnt = w_same_id ? 2'd1 : (2'(w_retire_hit) + 2'(w_cancel_hit));

  // Allocation only targets a clear bit, so set and clear never collide on one ID.
  generate
    for (genvar gi = 0; gi < NUM_IDS; gi++) begin : g_bit
      assign w_bitmap_next[gi] =
          (i_alloc_valid && (i_alloc_id == ID_WIDTH'(gi))) ||
          (r_bitmap[gi] &&
           !(w_retire_hit && (i_retire_id == ID_WIDTH'(gi))) &&
           !(w_cancel_hit && (i_cancel_id == ID_WIDTH'(gi))));
    end
  endgenerate

  // Bitmap and count update together; the count is the bitmap population.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bitmap <= '0;
      r_count  <= '0;
    end else begin
      r_bitmap <= w_bitmap_next;
      r_count  <= r_count + (ID_WIDTH+1)'(i_alloc_valid) - (ID_WIDTH+1)'(w_free_cnt);
    end
  end

  assign o_query_busy = r_bitmap[i_query_id];
  assign o_cancel_hit = w_cancel_hit;
  assign o_count      = r_count;

endmodule

// File: rtl/pipeline_issue.sv
// Head-of-pipeline issuer: tags accepted requests with in-order IDs, drives
// stage 0 under its stall, tracks IDs in flight and turns cancels into flushes.
module pipeline_issue
  import pipeline_issue_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = DEFAULT_ADDRESS_WIDTH,
  parameter int ID_WIDTH        = DEFAULT_ID_WIDTH,
  parameter int MAX_OUTSTANDING = 1 << ID_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  output logic                     req_ready,
  output logic [ADDRESS_WIDTH-1:0] out_address,
  output logic [ID_WIDTH-1:0]      out_id,
  output logic                     out_valid,
  input  logic                     in_stall,
  input  logic                     cancel_valid,
  input  logic [ID_WIDTH-1:0]      cancel_id,
  output logic                     out_flush,
  output logic [ID_WIDTH-1:0]      out_flush_id,
  input  logic                     retire_valid,
  input  logic [ID_WIDTH-1:0]      retire_id,
  input  logic                     drain,
  output logic                     drained,
  output logic [ID_WIDTH:0]        outstanding
);

  localparam logic [ID_WIDTH:0] MAX_CNT = (ID_WIDTH+1)'(MAX_OUTSTANDING);

  issue_state_e              r_state;
  issue_state_e              w_state_next;
  logic                      w_run;
  logic [ADDRESS_WIDTH-1:0]  r_out_address;
  logic [ID_WIDTH-1:0]       r_out_id;
  logic                      r_out_valid;
  logic                      r_flush;
  logic [ID_WIDTH-1:0]       r_flush_id;
  logic [ID_WIDTH-1:0]       r_next_id;
  logic                      r_drained;
  logic                      w_busy;
  logic                      w_cancel_hit;
  logic [ID_WIDTH:0]         w_count;
  logic                      w_can_alloc;
  logic                      w_accept;
  logic                      w_consume;
  logic                      w_kill;

  // State register for the run/drain control.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ISSUE_STATE_RUN;
    else          r_state <= w_state_next;
  end

  // Next-state: drain is a level, so the state simply follows it.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ISSUE_STATE_RUN:   if (drain)  w_state_next = ISSUE_STATE_DRAIN;
      ISSUE_STATE_DRAIN: if (!drain) w_state_next = ISSUE_STATE_RUN;
      default:           w_state_next = ISSUE_STATE_RUN;
    endcase
  end

  // State outputs: new allocations only happen in RUN.
  always_comb begin
    w_run = (r_state == ISSUE_STATE_RUN);
  end

  // IDs are never skipped: a busy next_id blocks allocation until it frees.
  assign w_can_alloc = w_run && !w_busy && (w_count < MAX_CNT);
  assign req_ready   = reset_n && w_can_alloc && (!r_out_valid || !in_stall);
  assign w_accept    = req_valid && req_ready;
  assign w_consume   = r_out_valid && !in_stall;
  assign w_kill      = w_cancel_hit && r_out_valid && (cancel_id == r_out_id);

  pipeline_issue_id_tracker #(
    .ID_WIDTH(ID_WIDTH)
  ) u_id_tracker (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_alloc_valid  (w_accept),
    .i_alloc_id     (r_next_id),
    .i_retire_valid (retire_valid),
    .i_retire_id    (retire_id),
    .i_cancel_valid (cancel_valid),
    .i_cancel_id    (cancel_id),
    .i_query_id     (r_next_id),
    .o_query_busy   (w_busy),
    .o_cancel_hit   (w_cancel_hit),
    .o_count        (w_count)
  );

  // Output beat register: load on accept, drop on cancel (even under stall) or consume.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_address <= '0;
      r_out_id      <= '0;
      r_out_valid   <= 1'b0;
      r_next_id     <= '0;
    end else begin
      if (w_accept) begin
        r_out_address <= req_address;
        r_out_id      <= r_next_id;
        r_out_valid   <= 1'b1;
        r_next_id     <= r_next_id + 1'b1;
      end else if (w_kill || w_consume) begin
        r_out_valid   <= 1'b0;
      end
    end
  end

  // One-cycle flush pulse for cancels that hit an outstanding ID; drained flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flush    <= 1'b0;
      r_flush_id <= '0;
      r_drained  <= 1'b0;
    end else begin
      r_flush   <= w_cancel_hit;
      if (w_cancel_hit) r_flush_id <= cancel_id;
      r_drained <= (r_state == ISSUE_STATE_DRAIN) && (w_count == '0);
    end
  end

  assign out_address  = r_out_address;
  assign out_id       = r_out_id;
  assign out_valid    = r_out_valid;
  assign out_flush    = r_flush;
  assign out_flush_id = r_flush_id;
  assign drained      = r_drained;
  assign outstanding  = w_count;

endmodule

// File: tb/tb_pipeline_issue.sv
// Directed bench for pipeline_issue with a 2-bit ID space (4 IDs in flight max).
module tb_pipeline_issue;

  localparam int AW = 16;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic [AW-1:0] req_address;
  logic          req_ready;
  logic [AW-1:0] out_address;
  logic [IW-1:0] out_id;
  logic          out_valid;
  logic          in_stall;
  logic          cancel_valid;
  logic [IW-1:0] cancel_id;
  logic          out_flush;
  logic [IW-1:0] out_flush_id;
  logic          retire_valid;
  logic [IW-1:0] retire_id;
  logic          drain;
  logic          drained;
  logic [IW:0]   outstanding;

  int n_total = 0;
  int n_bad   = 0;

  pipeline_issue #(
    .ADDRESS_WIDTH  (AW),
    .ID_WIDTH       (IW),
    .MAX_OUTSTANDING(4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_address  (req_address),
    .req_ready    (req_ready),
    .out_address  (out_address),
    .out_id       (out_id),
    .out_valid    (out_valid),
    .in_stall     (in_stall),
    .cancel_valid (cancel_valid),
    .cancel_id    (cancel_id),
    .out_flush    (out_flush),
    .out_flush_id (out_flush_id),
    .retire_valid (retire_valid),
    .retire_id    (retire_id),
    .drain        (drain),
    .drained      (drained),
    .outstanding  (outstanding)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("check %s = %0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string tag, input logic [AW-1:0] a, input logic [IW-1:0] id);
    check_value({tag, ".addr"},  32'(out_address), 32'(a));
    check_value({tag, ".id"},    32'(out_id),      32'(id));
    check_value({tag, ".valid"}, 32'(out_valid),   32'd1);
  endtask

  initial begin
    reset_n      = 1'b0;
    req_valid    = 1'b0;
    req_address  = '0;
    in_stall     = 1'b0;
    cancel_valid = 1'b0;
    cancel_id    = '0;
    retire_valid = 1'b0;
    retire_id    = '0;
    drain        = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_value("rst.out_valid",   32'(out_valid),   32'd0);
    check_value("rst.out_address", 32'(out_address), 32'd0);
    check_value("rst.out_flush",   32'(out_flush),   32'd0);
    check_value("rst.outstanding", 32'(outstanding), 32'd0);
    check_value("rst.req_ready",   32'(req_ready),   32'd0);
    reset_n = 1'b1;

    // Back-to-back accepts, 1-cycle latency.
    req_valid = 1'b1; req_address = 16'h0010;
    @(negedge clk); check_value("b2b.ready0", 32'(req_ready), 32'd1);
    step(); check_beat("b2b.beat0", 16'h0010, 2'd0);
    check_value("b2b.cnt1", 32'(outstanding), 32'd1);
    req_address = 16'h0020;
    step(); check_beat("b2b.beat1", 16'h0020, 2'd1);

    // Stall holds the beat and blocks new requests.
    req_address = 16'h0030; in_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check_value("stall.ready", 32'(req_ready), 32'd0);
      step(); check_beat("stall.hold", 16'h0020, 2'd1);
    end
    in_stall = 1'b0;
    @(negedge clk); check_value("release.ready", 32'(req_ready), 32'd1);
    step(); check_beat("release.beat2", 16'h0030, 2'd2);
    check_value("release.cnt3", 32'(outstanding), 32'd3);
    req_valid = 1'b0;
    step(); check_value("idle.valid", 32'(out_valid), 32'd0);
    check_value("idle.cnt3", 32'(outstanding), 32'd3);

    // Fill the ID space, then wrap onto a busy id0.
    req_valid = 1'b1; req_address = 16'h0040;
    step(); check_beat("fill.beat3", 16'h0040, 2'd3);
    check_value("fill.cnt4", 32'(outstanding), 32'd4);
    req_address = 16'h0050;
    @(negedge clk); check_value("wrap.ready_full", 32'(req_ready), 32'd0);
    step(); check_value("wrap.no_beat", 32'(out_valid), 32'd0);
    retire_valid = 1'b1; retire_id = 2'd0;
    @(negedge clk); check_value("wrap.ready_busy", 32'(req_ready), 32'd0);
    step(); retire_valid = 1'b0;
    check_value("wrap.cnt3", 32'(outstanding), 32'd3);
    @(negedge clk); check_value("wrap.ready_free", 32'(req_ready), 32'd1);
    step(); check_beat("wrap.beat_id0", 16'h0050, 2'd0);
    check_value("wrap.cnt4", 32'(outstanding), 32'd4);
    @(negedge clk); check_value("wrap.ready_again", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    step(); check_value("wrap.single", 32'(out_valid), 32'd0);

    // Cancel an outstanding ID, then repeat it.
    cancel_valid = 1'b1; cancel_id = 2'd1;
    step(); check_value("cancel.flush", 32'(out_flush), 32'd1);
    check_value("cancel.flush_id", 32'(out_flush_id), 32'd1);
    check_value("cancel.cnt3", 32'(outstanding), 32'd3);
    step(); check_value("recancel.flush", 32'(out_flush), 32'd0);
    check_value("recancel.cnt3", 32'(outstanding), 32'd3);
    cancel_valid = 1'b0;

    // Cancel the held beat under stall.
    req_valid = 1'b1; req_address = 16'h0060;
    step(); check_beat("held.beat_id1", 16'h0060, 2'd1);
    req_valid = 1'b0; in_stall = 1'b1; cancel_valid = 1'b1; cancel_id = 2'd1;
    step(); check_value("held.killed", 32'(out_valid), 32'd0);
    check_value("held.flush", 32'(out_flush), 32'd1);
    check_value("held.cnt3", 32'(outstanding), 32'd3);
    cancel_valid = 1'b0; in_stall = 1'b0;

    // Retire and cancel the same ID in one cycle.
    retire_valid = 1'b1; retire_id = 2'd2; cancel_valid = 1'b1; cancel_id = 2'd2;
    step(); check_value("both.cnt2", 32'(outstanding), 32'd2);
    check_value("both.flush", 32'(out_flush), 32'd1);
    check_value("both.flush_id", 32'(out_flush_id), 32'd2);
    retire_valid = 1'b0; cancel_valid = 1'b0;

    // Drain with ids 0 and 3 outstanding.
    drain = 1'b1;
    step();
    req_valid = 1'b1; req_address = 16'h0070;
    @(negedge clk); check_value("drain.ready", 32'(req_ready), 32'd0);
    retire_valid = 1'b1; retire_id = 2'd0;
    step(); check_value("drain.cnt1", 32'(outstanding), 32'd1);
    check_value("drain.not_yet", 32'(drained), 32'd0);
    retire_id = 2'd3;
    step(); check_value("drain.cnt0", 32'(outstanding), 32'd0);
    retire_valid = 1'b0;
    step(); check_value("drain.drained", 32'(drained), 32'd1);
    check_value("drain.no_beat", 32'(out_valid), 32'd0);
    drain = 1'b0;
    step();
    step(); check_beat("resume.beat_id2", 16'h0070, 2'd2);
    check_value("resume.cnt1", 32'(outstanding), 32'd1);

    // Asynchronous reset mid-traffic, sampled between clock edges.
    req_valid = 1'b0; in_stall = 1'b1;
    #2; reset_n = 1'b0;
    #1;
    check_value("arst.out_valid",   32'(out_valid),   32'd0);
    check_value("arst.out_address", 32'(out_address), 32'd0);
    check_value("arst.out_id",      32'(out_id),      32'd0);
    check_value("arst.outstanding", 32'(outstanding), 32'd0);
    check_value("arst.req_ready",   32'(req_ready),   32'd0);
    reset_n = 1'b1; in_stall = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
